uart_rx_ovs: RTL

Oversampling UART receiver. It has runtime-selectable baud divisor, parity, stop-bit count and bit order, and uses 3-sample majority voting per bit. It detects parity, framing and break errors, and buffers received frames in an internal FIFO drained through a valid/ready handshake. It sits between the pad-synchronised RX line and any host-side consumer (CSR block, DMA, command parser). It replaces fixed-configuration receivers where the baud rate or frame format must change without resynthesis.

---
 rtl/uart_pkg.sv | 33 +++
 rtl/uart_sync_fifo.sv | 58 +++++
 rtl/uart_rx_ovs.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: check modes, receiver states, FIFO entry layout
// and the ceiling-log2 helper used by the TX/RX blocks.
package uart_pkg;

  typedef enum logic [1:0] {
    CHK_NONE = 2'd0,
    CHK_EVEN = 2'd1,
    CHK_ODD  = 2'd2,
    CHK_RSVD = 2'd3
  } chk_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  // Flag positions above the data field of a FIFO entry: {break, ferr, perr, data}
  localparam int unsigned ENT_PERR  = 0;
  localparam int unsigned ENT_FERR  = 1;
  localparam int unsigned ENT_BRK   = 2;
  localparam int unsigned ENT_FLAGS = 3;

  function automatic int unsigned F_width(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Generic synchronous first-word-fall-through FIFO with occupancy output.
// Head data reads as zero while empty.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int unsigned P_WIDTH = 8,
  parameter int unsigned P_DEPTH = 16
) (
  input  logic                      I_clk,
  input  logic                      I_rst,
  input  logic                      I_wr,
  input  logic [P_WIDTH-1:0]        I_wdata,
  input  logic                      I_rd,
  output logic [P_WIDTH-1:0]        O_rdata,
  output logic                      O_empty,
  output logic                      O_full,
  output logic [F_width(P_DEPTH):0] O_fill
);

  localparam int unsigned AW = F_width(P_DEPTH);

  logic [P_WIDTH-1:0] mem_q [P_DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [AW:0]        cnt_q, cnt_d;
  logic               push, pop;

  // A write while full is accepted only if the head leaves in the same cycle.
  always_comb begin
    O_empty  = (cnt_q == '0);
    O_full   = (cnt_q == (AW+1)'(P_DEPTH));
    pop      = I_rd & ~O_empty;
    push     = I_wr & (~O_full | pop);
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    cnt_d    = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge I_clk) begin
    if (push) mem_q[wr_ptr_q] <= I_wdata;
  end

  assign O_rdata = O_empty ? '0 : mem_q[rd_ptr_q];
  assign O_fill  = cnt_q;

endmodule

// File: rtl/uart_rx_ovs.sv
// Oversampling UART receiver with 3-sample majority vote, runtime frame format,
// parity/framing/break detection and a FWFT frame FIFO.
//   state     | meaning
//   ST_IDLE   | waiting for a synced 1->0 edge on the line
//   ST_START  | checking the start bit; a high vote aborts as a false start
//   ST_DATA   | shifting in C_DATA_WIDTH data bits
//   ST_PARITY | comparing the parity bit (only when a check mode is active)
//   ST_STOP   | checking 1 or 2 stop bits, entry written at the last stop vote
module uart_rx_ovs
  import uart_pkg::*;
#(
  parameter int unsigned C_DATA_WIDTH  = 8,
  parameter int unsigned C_OVS         = 16,
  parameter int unsigned C_DIV_WIDTH   = 16,
  parameter int unsigned C_FIFO_DEPTH  = 16,
  parameter int unsigned C_SYNC_STAGES = 2
) (
  input  logic                           I_clk,
  input  logic                           I_rst,
  input  logic                           I_rx,
  input  logic [C_DIV_WIDTH-1:0]         I_div,
  input  logic [1:0]                     I_check,
  input  logic                           I_stop,
  input  logic                           I_msb,
  output logic [C_DATA_WIDTH-1:0]        O_data,
  output logic                           O_perr,
  output logic                           O_ferr,
  output logic                           O_break,
  output logic                           O_data_v,
  input  logic                           I_data_rdy,
  output logic                           O_overflow,
  output logic [F_width(C_FIFO_DEPTH):0] O_fill,
  output logic                           O_busy
);

  localparam int unsigned SW = F_width(C_OVS);
  localparam int unsigned BW = F_width(C_DATA_WIDTH);
  localparam int unsigned EW = C_DATA_WIDTH + ENT_FLAGS;
  localparam logic [SW-1:0] S_SMP0 = SW'(C_OVS/2 - 1);
  localparam logic [SW-1:0] S_SMP1 = SW'(C_OVS/2);
  localparam logic [SW-1:0] S_VOTE = SW'(C_OVS/2 + 1);
  localparam logic [SW-1:0] S_LAST = SW'(C_OVS - 1);

  logic [C_SYNC_STAGES-1:0] sync_q, sync_d;
  logic                     edge_q, edge_d;
  rx_state_e                state_q, state_d;
  logic [C_DIV_WIDTH-1:0]   tick_q, tick_d, div_q, div_d;
  logic [SW-1:0]            s_q, s_d;
  logic [BW-1:0]            bit_q, bit_d;
  logic [1:0]               smp_q, smp_d;
  logic [C_DATA_WIDTH-1:0]  shift_q, shift_d;
  logic                     perr_q, perr_d, ferr_q, ferr_d, ones_q, ones_d;
  chk_e                     chk_q, chk_d;
  logic                     stop_q, stop_d, msb_q, msb_d;
  logic                     wr_q, wr_d, ovf_q, ovf_d;
  logic [EW-1:0]            went_q, went_d;
  logic                     rx_s, tick, vote, at_vote, at_last;
  logic [EW-1:0]            head;
  logic                     fifo_empty, fifo_full;

  assign rx_s    = sync_q[C_SYNC_STAGES-1];
  assign tick    = (tick_q == div_q);
  assign vote    = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s) | (smp_q[1] & rx_s);
  assign at_vote = tick & (s_q == S_VOTE);
  assign at_last = tick & (s_q == S_LAST);

  always_comb begin
    sync_d  = {sync_q[C_SYNC_STAGES-2:0], I_rx};
    edge_d  = rx_s;
    state_d = state_q;
    tick_d  = tick_q;
    div_d   = div_q;
    s_d     = s_q;
    bit_d   = bit_q;
    smp_d   = smp_q;
    shift_d = shift_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    ones_d  = ones_q;
    chk_d   = chk_q;
    stop_d  = stop_q;
    msb_d   = msb_q;
    wr_d    = 1'b0;
    went_d  = went_q;
    ovf_d   = wr_q & fifo_full & ~I_data_rdy;

    if (state_q == ST_IDLE) begin
      // Frame phase and format are fixed at the detected edge.
      if (edge_q && !rx_s) begin
        state_d = ST_START;
        tick_d  = '0;
        s_d     = '0;
        bit_d   = '0;
        shift_d = '0;
        perr_d  = 1'b0;
        ferr_d  = 1'b0;
        ones_d  = 1'b0;
        div_d   = I_div;
        chk_d   = chk_e'(I_check);
        stop_d  = I_stop;
        msb_d   = I_msb;
      end
    end else begin
      tick_d = tick ? '0 : tick_q + C_DIV_WIDTH'(1);
      if (tick) begin
        s_d = (s_q == S_LAST) ? '0 : s_q + SW'(1);
        if (s_q == S_SMP0) smp_d[0] = rx_s;
        if (s_q == S_SMP1) smp_d[1] = rx_s;
      end
      if (at_vote) ones_d = ones_q | vote;

      case (state_q)
        ST_START: begin
          if (at_vote && vote) state_d = ST_IDLE;
          else if (at_last)    state_d = ST_DATA;
        end
        ST_DATA: begin
          if (at_vote) begin
            shift_d = msb_q ? {shift_q[C_DATA_WIDTH-2:0], vote}
                            : {vote, shift_q[C_DATA_WIDTH-1:1]};
          end
          if (at_last) begin
            if (bit_q == BW'(C_DATA_WIDTH - 1)) begin
              bit_d   = '0;
              state_d = (chk_q == CHK_EVEN || chk_q == CHK_ODD) ? ST_PARITY : ST_STOP;
            end else begin
              bit_d = bit_q + BW'(1);
            end
          end
        end
        ST_PARITY: begin
          if (at_vote) perr_d = vote ^ (^shift_q) ^ (chk_q == CHK_ODD);
          if (at_last) state_d = ST_STOP;
        end
        ST_STOP: begin
          if (at_vote) begin
            ferr_d = ferr_q | ~vote;
            if (bit_q == BW'(stop_q)) begin
              wr_d                               = 1'b1;
              went_d[C_DATA_WIDTH-1:0]           = shift_q;
              went_d[C_DATA_WIDTH + ENT_PERR]    = perr_q;
              went_d[C_DATA_WIDTH + ENT_FERR]    = ferr_d;
              went_d[C_DATA_WIDTH + ENT_BRK]     = ~ones_d;
              state_d                            = ST_IDLE;
            end
          end else if (at_last) begin
            bit_d = bit_q + BW'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      sync_q  <= '1;
      edge_q  <= 1'b1;
      state_q <= ST_IDLE;
      tick_q  <= '0;
      div_q   <= '0;
      s_q     <= '0;
      bit_q   <= '0;
      smp_q   <= '0;
      shift_q <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ones_q  <= 1'b0;
      chk_q   <= CHK_NONE;
      stop_q  <= 1'b0;
      msb_q   <= 1'b0;
      wr_q    <= 1'b0;
      went_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      edge_q  <= edge_d;
      state_q <= state_d;
      tick_q  <= tick_d;
      div_q   <= div_d;
      s_q     <= s_d;
      bit_q   <= bit_d;
      smp_q   <= smp_d;
      shift_q <= shift_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      ones_q  <= ones_d;
      chk_q   <= chk_d;
      stop_q  <= stop_d;
      msb_q   <= msb_d;
      wr_q    <= wr_d;
      went_q  <= went_d;
      ovf_q   <= ovf_d;
    end
  end

  uart_sync_fifo #(
    .P_WIDTH (EW),
    .P_DEPTH (C_FIFO_DEPTH)
  ) u_fifo (
    .I_clk   (I_clk),
    .I_rst   (I_rst),
    .I_wr    (wr_q),
    .I_wdata (went_q),
    .I_rd    (I_data_rdy),
    .O_rdata (head),
    .O_empty (fifo_empty),
    .O_full  (fifo_full),
    .O_fill  (O_fill)
  );

  assign O_data     = head[C_DATA_WIDTH-1:0];
  assign O_perr     = head[C_DATA_WIDTH + ENT_PERR];
  assign O_ferr     = head[C_DATA_WIDTH + ENT_FERR];
  assign O_break    = head[C_DATA_WIDTH + ENT_BRK];
  assign O_data_v   = ~fifo_empty;
  assign O_overflow = ovf_q;
  assign O_busy     = (state_q != ST_IDLE) | wr_q;

endmodule
